// File: rtl/alu_cmd_issuer_if.sv
// Command / ALU / response bus of the 4-bit ALU command issuer.
// master: the issuer (accepts commands, drives the ALU, returns responses).
// slave : the surrounding system (offers commands, hosts the ALU, consumes responses).
// Optional feature macro: ALU_ISSUER_CHAIN_EN adds cmd_chain.
interface alu_cmd_issuer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
`ifdef ALU_ISSUER_CHAIN_EN
    logic       cmd_chain;
`endif
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_sel;
    logic [4:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_data;
    logic [3:0] rsp_op;
    logic       rsp_err;

    modport master (
`ifdef ALU_ISSUER_CHAIN_EN
        input  cmd_chain,
`endif
        input  cmd_valid,
        output cmd_ready,
        input  cmd_op,
        input  cmd_a,
        input  cmd_b,
        output alu_a,
        output alu_b,
        output alu_sel,
        input  alu_out,
        output rsp_valid,
        input  rsp_ready,
        output rsp_data,
        output rsp_op,
        output rsp_err
    );

    modport slave (
`ifdef ALU_ISSUER_CHAIN_EN
        output cmd_chain,
`endif
        output cmd_valid,
        input  cmd_ready,
        output cmd_op,
        output cmd_a,
        output cmd_b,
        input  alu_a,
        input  alu_b,
        input  alu_sel,
        output alu_out,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_data,
        input  rsp_op,
        input  rsp_err
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: initiator side of a 4-bit combinational ALU.
// Commands are queued in a small FIFO, issued one at a time onto registered
// ALU operand/select lines, and the 5-bit result is captured one settle cycle
// later and returned on a valid/ready response stream in command order.
// Op codes 13..15 are not issued; they return an error response immediately.
// Optional feature macro: ALU_ISSUER_CHAIN_EN (chained operand a from the
// last non-error result, adds cmd_chain to the bus).
module alu_cmd_issuer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_issuer_if.master    bus,
    output logic                busy,
    output logic [CNT_W-1:0]    op_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef ALU_ISSUER_CHAIN_EN
    localparam int ENTRY_W = 13;
`else
    localparam int ENTRY_W = 12;
`endif
    localparam logic [3:0] MAX_OP = 4'd12;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("alu_cmd_issuer: FIFO_DEPTH must be a power of two and >= 2");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    // command FIFO: one extra pointer bit distinguishes full from empty
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;

    logic [ENTRY_W-1:0] head;
    logic [3:0]         head_op;
    logic [3:0]         head_a;
    logic [3:0]         head_b;
    logic [3:0]         issue_a;

    logic               issue_ld;
    logic               err_ld;
    logic               capture;
    logic               rsp_hs;

    logic [3:0]         alu_a_r;
    logic [3:0]         alu_b_r;
    logic [3:0]         alu_sel_r;
    logic [4:0]         rsp_data_r;
    logic [3:0]         rsp_op_r;
    logic               rsp_err_r;
    logic [CNT_W-1:0]   op_count_r;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Ready depends only on registered occupancy, so a pop in the same cycle
    // never lets a push into a full FIFO.
    assign bus.cmd_ready = !fifo_full && !rst;
    assign push          = bus.cmd_valid && bus.cmd_ready;

    assign head    = mem[rd_ptr[AW-1:0]];
    assign head_op = head[11:8];
    assign head_a  = head[7:4];
    assign head_b  = head[3:0];

`ifdef ALU_ISSUER_CHAIN_EN
    logic [3:0] last_res;
    logic       head_chain;

    assign head_chain = head[12];
    assign issue_a    = head_chain ? last_res : head_a;

    // last non-error result, feeds operand a of chained commands
    always_ff @(posedge clk) begin
        if (rst) begin
            last_res <= 4'd0;
        end else if (capture) begin
            last_res <= bus.alu_out[3:0];
        end
    end
`else
    assign issue_a = head_a;
`endif

    // FIFO storage write; contents need no reset since the pointers flush it
    always_ff @(posedge clk) begin
        if (push) begin
`ifdef ALU_ISSUER_CHAIN_EN
            mem[wr_ptr[AW-1:0]] <= {bus.cmd_chain, bus.cmd_op, bus.cmd_a, bus.cmd_b};
`else
            mem[wr_ptr[AW-1:0]] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
`endif
        end
    end

    // FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and per-cycle strobes
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        issue_ld  = 1'b0;
        err_ld    = 1'b0;
        capture   = 1'b0;
        rsp_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head_op <= MAX_OP) begin
                        issue_ld  = 1'b1;
                        state_nxt = ISSUE;
                    end else begin
                        err_ld    = 1'b1;
                        state_nxt = DONE;
                    end
                end
            end
            ISSUE: begin
                // operands held for a full cycle so the ALU output settles
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                capture   = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    rsp_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ALU drive lines and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a_r    <= 4'd0;
            alu_b_r    <= 4'd0;
            alu_sel_r  <= 4'd0;
            rsp_data_r <= 5'd0;
            rsp_op_r   <= 4'd0;
            rsp_err_r  <= 1'b0;
        end else begin
            if (issue_ld) begin
                alu_a_r   <= issue_a;
                alu_b_r   <= head_b;
                alu_sel_r <= head_op;
            end
            if (err_ld) begin
                rsp_data_r <= 5'd0;
                rsp_op_r   <= head_op;
                rsp_err_r  <= 1'b1;
            end
            if (capture) begin
                rsp_data_r <= bus.alu_out;
                rsp_op_r   <= alu_sel_r;
                rsp_err_r  <= 1'b0;
            end
        end
    end

    // completed-response counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_r <= '0;
        end else if (rsp_hs) begin
            op_count_r <= op_count_r + 1'b1;
        end
    end

    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.alu_sel   = alu_sel_r;
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_op    = rsp_op_r;
    assign bus.rsp_err   = rsp_err_r;
    assign op_count      = op_count_r;
    assign busy          = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed testbench for alu_cmd_issuer with a behavioural 13-op ALU.
// Optional feature macro: ALU_ISSUER_CHAIN_EN enables the chained-operand steps.
module tb_alu_cmd_issuer;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [7:0] op_count;

    int compared   = 0;
    int mismatched = 0;
    int cycle      = 0;

    alu_cmd_issuer_if ifc();

    alu_cmd_issuer #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifc.master),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    // ALU op set: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not a, 6 a<<1, 7 a>>1,
    // 8 a+1, 9 a-1, 10 pass a, 11 pass b, 12 a<b
    function automatic logic [4:0] alu_model(input logic [3:0] sel, input logic [3:0] a,
                                             input logic [3:0] b);
        logic [4:0] ea;
        logic [4:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        case (sel)
            4'd0:    return ea + eb;
            4'd1:    return ea - eb;
            4'd2:    return ea & eb;
            4'd3:    return ea | eb;
            4'd4:    return ea ^ eb;
            4'd5:    return {1'b0, ~a};
            4'd6:    return ea << 1;
            4'd7:    return ea >> 1;
            4'd8:    return ea + 5'd1;
            4'd9:    return ea - 5'd1;
            4'd10:   return ea;
            4'd11:   return eb;
            4'd12:   return (a < b) ? 5'd1 : 5'd0;
            default: return 5'd0;
        endcase
    endfunction

    always_comb ifc.alu_out = alu_model(ifc.alu_sel, ifc.alu_a, ifc.alu_b);

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        int n;
        n = 0;
        ifc.cmd_op    = op;
        ifc.cmd_a     = a;
        ifc.cmd_b     = b;
        ifc.cmd_valid = 1'b1;
        while (!ifc.cmd_ready && n < 50) begin
            step();
            n++;
        end
        check("push_wait", (n < 50), 1);
        step();
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check(tag, (n < 200), 1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v_op  [6];
        logic [3:0] v_a   [6];
        logic [4:0] v_exp [6];
        int idx;
        int acc_idx;
        int last_hs;
        int n;
        logic accept_now;

        v_op  = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};
        v_a   = '{4'd6, 4'd9, 4'd9, 4'd15, 4'd0, 4'd12};
        v_exp = '{5'h09, 5'h12, 5'h04, 5'h10, 5'h1F, 5'h0C};

        rst           = 1'b1;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op    = 4'd0;
        ifc.cmd_a     = 4'd0;
        ifc.cmd_b     = 4'd0;
        ifc.rsp_ready = 1'b0;
`ifdef ALU_ISSUER_CHAIN_EN
        ifc.cmd_chain = 1'b0;
`endif

        // 1. reset held for two edges
        step();
        step();
        check("rst_cmd_ready", ifc.cmd_ready, 0);
        check("rst_rsp_valid", ifc.rsp_valid, 0);
        check("rst_alu_a", ifc.alu_a, 0);
        check("rst_alu_b", ifc.alu_b, 0);
        check("rst_alu_sel", ifc.alu_sel, 0);
        check("rst_op_count", op_count, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        step();
        check("post_rst_cmd_ready", ifc.cmd_ready, 1);

        // 2. valid op latency: pop at E1, response after E3
        ifc.rsp_ready = 1'b1;
        ifc.cmd_op    = 4'd0;
        ifc.cmd_a     = 4'd9;
        ifc.cmd_b     = 4'd8;
        ifc.cmd_valid = 1'b1;
        step();
        ifc.cmd_valid = 1'b0;
        step();
        check("add_e1_valid", ifc.rsp_valid, 0);
        check("add_e1_alu_a", ifc.alu_a, 9);
        check("add_e1_alu_b", ifc.alu_b, 8);
        check("add_e1_alu_sel", ifc.alu_sel, 0);
        check("add_e1_busy", busy, 1);
        step();
        check("add_e2_valid", ifc.rsp_valid, 0);
        step();
        check("add_e3_valid", ifc.rsp_valid, 1);
        check("add_data", ifc.rsp_data, 5'h11);
        check("add_err", ifc.rsp_err, 0);
        check("add_op", ifc.rsp_op, 0);
        check("add_count_before", op_count, 0);
        step();
        check("add_valid_after_hs", ifc.rsp_valid, 0);
        check("add_count", op_count, 1);

        // 3. invalid op: response after E1, ALU lines untouched
        ifc.cmd_op    = 4'd14;
        ifc.cmd_a     = 4'd3;
        ifc.cmd_b     = 4'd3;
        ifc.cmd_valid = 1'b1;
        step();
        ifc.cmd_valid = 1'b0;
        step();
        check("err_e1_valid", ifc.rsp_valid, 1);
        check("err_flag", ifc.rsp_err, 1);
        check("err_data", ifc.rsp_data, 0);
        check("err_op", ifc.rsp_op, 14);
        check("err_alu_sel", ifc.alu_sel, 0);
        check("err_alu_a", ifc.alu_a, 9);
        step();
        check("err_count", op_count, 2);
        check("err_busy", busy, 0);

        // 4. back-pressure: one in flight plus four buffered, then drain
        ifc.rsp_ready = 1'b0;
        ifc.cmd_b     = 4'd3;
        for (int i = 0; i < 5; i++) begin
            ifc.cmd_op    = v_op[i];
            ifc.cmd_a     = v_a[i];
            ifc.cmd_valid = 1'b1;
            check($sformatf("fill_ready%0d", i), ifc.cmd_ready, 1);
            step();
        end
        ifc.cmd_op = v_op[5];
        ifc.cmd_a  = v_a[5];
        check("full_ready", ifc.cmd_ready, 0);
        step();
        step();
        check("full_hold_ready", ifc.cmd_ready, 0);
        check("hold_valid", ifc.rsp_valid, 1);
        check("hold_data", ifc.rsp_data, 5'h09);
        ifc.rsp_ready = 1'b1;
        idx     = 0;
        acc_idx = -1;
        last_hs = -1;
        n       = 0;
        while (idx < 6 && n < 100) begin
            if (ifc.rsp_valid) begin
                check($sformatf("drain_data%0d", idx), ifc.rsp_data, v_exp[idx]);
                check($sformatf("drain_op%0d", idx), ifc.rsp_op, v_op[idx]);
                if (last_hs >= 0) begin
                    check($sformatf("drain_interval%0d", idx), cycle - last_hs, 4);
                end
                last_hs = cycle;
                idx++;
            end
            accept_now = ifc.cmd_valid && ifc.cmd_ready;
            if (accept_now) begin
                acc_idx = idx;
            end
            step();
            n++;
            if (accept_now) begin
                ifc.cmd_valid = 1'b0;
            end
        end
        check("drain_count", idx, 6);
        check("sixth_accept_after", acc_idx, 1);
        check("drain_op_count", op_count, 8);
        check("drain_busy", busy, 0);

        // 5. reset while a response is held and two entries are queued
        ifc.rsp_ready = 1'b0;
        push_cmd(4'd0, 4'd1, 4'd1);
        push_cmd(4'd2, 4'd6, 4'd3);
        push_cmd(4'd3, 4'd6, 4'd3);
        n = 0;
        while (!ifc.rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("mid_valid", ifc.rsp_valid, 1);
        check("mid_data", ifc.rsp_data, 5'h02);
        rst = 1'b1;
        step();
        check("mid_rst_valid", ifc.rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", op_count, 0);
        check("mid_rst_ready", ifc.cmd_ready, 0);
        check("mid_rst_alu_sel", ifc.alu_sel, 0);
        check("mid_rst_data", ifc.rsp_data, 0);
        rst = 1'b0;
        ifc.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("no_stale%0d", i), ifc.rsp_valid, 0);
        end
        check("post_mid_count", op_count, 0);
        check("post_mid_busy", busy, 0);

        // counter wrap using fast error responses
        for (int i = 0; i < 255; i++) begin
            push_cmd(4'd13, 4'd0, 4'd0);
        end
        wait_idle("wrap_idle255");
        check("count_255", op_count, 8'hFF);
        push_cmd(4'd15, 4'd0, 4'd0);
        wait_idle("wrap_idle256");
        check("count_wrap", op_count, 0);

`ifdef ALU_ISSUER_CHAIN_EN
        // chained operand a from the previous result
        ifc.cmd_chain = 1'b0;
        push_cmd(4'd0, 4'd3, 4'd4);
        ifc.cmd_chain = 1'b1;
        push_cmd(4'd0, 4'd15, 4'd1);
        ifc.cmd_chain = 1'b0;
        idx = 0;
        n   = 0;
        while (idx < 2 && n < 50) begin
            if (ifc.rsp_valid) begin
                check($sformatf("chain_data%0d", idx), ifc.rsp_data, (idx == 0) ? 7 : 8);
                idx++;
            end
            step();
            n++;
        end
        check("chain_count", idx, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
